// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_stream_drain_pkg;

  localparam int FIFO_DATA_WIDTH = 16;
  localparam int SKID_DEPTH      = 2;

  typedef logic [FIFO_DATA_WIDTH-1:0] word_t;
  typedef logic [1:0]                 occ_t;

  // True when a new read still fits: occ + inflight < SKID_DEPTH + pop.
  function automatic logic has_credit(input occ_t occ, input logic inflight, input logic pop);
    return ({1'b0, occ} + {2'b00, inflight}) < (3'(SKID_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/fifo_stream_drain_skid_buf2.sv
// Two-entry in-order register buffer; head_data is always the oldest entry.
module skid_buf2
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
  occ_t                  occ_r, occ_nxt_s;

  // Next-state of the two entries and occupancy for every push/pop combination.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    occ_nxt_s  = occ_r;
    case ({push, pop})
      2'b10: begin
        if (occ_r == 2'd0) begin
          head_nxt_s = push_data;
          occ_nxt_s  = 2'd1;
        end else if (occ_r == 2'd1) begin
          tail_nxt_s = push_data;
          occ_nxt_s  = 2'd2;
        end else begin
          occ_nxt_s  = occ_r;
        end
      end
      2'b01: begin
        head_nxt_s = tail_r;
        if (occ_r != 2'd0) begin
          occ_nxt_s = occ_r - 2'd1;
        end else begin
          occ_nxt_s = occ_r;
        end
      end
      2'b11: begin
        // Head leaves; the new word lands behind whatever remains.
        if (occ_r == 2'd2) begin
          head_nxt_s = tail_r;
          tail_nxt_s = push_data;
        end else begin
          head_nxt_s = push_data;
        end
      end
      default: begin
        occ_nxt_s = occ_r;
      end
    endcase
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {DATA_WIDTH{1'b0}};
      tail_r <= {DATA_WIDTH{1'b0}};
      occ_r  <= 2'd0;
    end else begin
      head_r <= head_nxt_s;
      tail_r <= tail_nxt_s;
      occ_r  <= occ_nxt_s;
    end
  end

  assign head_data = head_r;
  assign occ       = occ_r;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a zero-bubble valid/ready stream via a 2-entry skid buffer.
// Optional stall counter enabled by defining DRAIN_STALL_CNT_EN.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic                 inflight_r, m_valid_r, pop_s, rd_en_s;
  occ_t                 occ_s, occ_nxt_s;
  logic [CNT_WIDTH-1:0] beat_cnt_r;

  assign pop_s     = m_valid_r & m_ready;
  assign occ_nxt_s = occ_s + {1'b0, inflight_r} - {1'b0, pop_s};

  // Read request: only when the FIFO has data and the buffer can absorb the word.
  always_comb begin
    rd_en_s = 1'b0;
    if (rst) begin
      rd_en_s = 1'b0;
    end else if (!fifo_empty && has_credit(occ_s, inflight_r, pop_s)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data (fifo_dout),
    .pop       (pop_s),
    .head_data (m_data),
    .occ       (occ_s)
  );

  // In-flight read tracking, registered valid and handshake counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
      m_valid_r  <= 1'b0;
      beat_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      inflight_r <= rd_en_s;
      m_valid_r  <= (occ_nxt_s != 2'd0);
      if (pop_s) begin
        beat_cnt_r <= beat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating count of cycles where a word waits on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (m_valid_r && !m_ready && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = {CNT_WIDTH{1'b0}};
`endif

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = m_valid_r;
  assign beat_cnt   = beat_cnt_r;

endmodule
